// File: rtl/audio_sched.sv
// audio_sched: time-multiplexes one sample ROM between background music and sound effects.
// Define AUDIO_SCHED_SFX_MIX_EN to mix music and effect with saturation instead of replacing music.
module audio_sched #(
    parameter int MUSIC_END = 13435,
    parameter int SFX0_BASE = 13436,
    parameter int SFX1_BASE = 15484,
    parameter int SFX_LEN   = 2048,
    parameter int RATE_DIV  = 10
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        INIT_FINISH,
    input  logic        data_over,
    input  logic        music_en,
    input  logic [1:0]  sfx_req,
    output logic [15:0] rom_addr,
    input  logic [15:0] rom_data,
    output logic [15:0] sample,
    output logic        sample_valid,
    output logic        sfx_busy,
    output logic        overrun
);
    typedef enum logic [2:0] {IDLE, WAIT, M_ADDR, M_DATA, S_ADDR, S_DATA, EMIT} state_t;
    localparam logic [15:0] ME    = 16'(MUSIC_END);
    localparam logic [15:0] B0    = 16'(SFX0_BASE);
    localparam logic [15:0] B1    = 16'(SFX1_BASE);
    localparam logic [15:0] LAST  = 16'(SFX_LEN - 1);
    localparam logic [15:0] DLAST = 16'(RATE_DIV - 1);
    state_t      state_q;
    logic [15:0] maddr_q, div_q, off_q, mus_q, mix_d;
    logic        act_q, id_q, pend_q, pid_q;
    logic        req_id_d, take_d, sel_d, sel_id_d;
    // Effect id 0 is the line clear (highest priority), id 1 the drop.
    assign req_id_d = ~sfx_req[0];
    assign take_d   = |sfx_req && (!sfx_busy || (!req_id_d && (pend_q ? pid_q : id_q)));
    assign sel_d    = take_d | pend_q;
    assign sel_id_d = take_d ? req_id_d : pid_q;
    assign sfx_busy = act_q | pend_q;
`ifdef AUDIO_SCHED_SFX_MIX_EN
    logic [15:0] eff_d;
    logic [16:0] sum_d;
    always_comb begin
        eff_d = act_q ? rom_data : 16'h0000;
        sum_d = {mus_q[15], mus_q} + {eff_d[15], eff_d};
        mix_d = (sum_d[16] != sum_d[15]) ? (sum_d[16] ? 16'h8000 : 16'h7FFF) : sum_d[15:0];
    end
`else
    assign mix_d = act_q ? rom_data : mus_q;
`endif
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= IDLE;
            rom_addr     <= '0;
            sample       <= '0;
            sample_valid <= 1'b0;
            overrun      <= 1'b0;
            maddr_q      <= '0;
            div_q        <= '0;
            off_q        <= '0;
            mus_q        <= '0;
            act_q        <= 1'b0;
            id_q         <= 1'b0;
            pend_q       <= 1'b0;
            pid_q        <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            if (data_over && INIT_FINISH && state_q != WAIT) overrun <= 1'b1;
            if (take_d) begin
                pend_q <= 1'b1;
                pid_q  <= req_id_d;
            end
            if (!INIT_FINISH) state_q <= IDLE;
            else case (state_q)
                IDLE: state_q <= WAIT;
                WAIT: if (data_over) begin
                    state_q  <= M_ADDR;
                    rom_addr <= maddr_q;
                    // A pending (or same-cycle) request starts on this tick at offset 0.
                    if (sel_d) begin
                        act_q  <= 1'b1;
                        id_q   <= sel_id_d;
                        off_q  <= '0;
                        pend_q <= 1'b0;
                    end
                end
                M_ADDR: state_q <= M_DATA;
                M_DATA: begin
                    state_q  <= S_ADDR;
                    mus_q    <= music_en ? rom_data : 16'h0000;
                    rom_addr <= (id_q ? B1 : B0) + off_q;
                end
                S_ADDR: state_q <= S_DATA;
                S_DATA: begin
                    state_q      <= EMIT;
                    sample       <= mix_d;
                    sample_valid <= 1'b1;
                end
                EMIT: begin
                    state_q <= WAIT;
                    if (music_en) begin
                        div_q <= (div_q == DLAST) ? '0 : div_q + 1'b1;
                        if (div_q == DLAST) maddr_q <= (maddr_q == ME) ? '0 : maddr_q + 1'b1;
                    end
                    if (act_q) begin
                        act_q <= off_q != LAST;
                        off_q <= (off_q == LAST) ? '0 : off_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_audio_sched.sv
// tb_audio_sched: randomized tick-level checking of audio_sched against a behavioural scheduler model.
module tb_audio_sched;
    localparam int ME = 20, B0 = 100, B1 = 200, LEN = 16, RD = 3;
    logic Clk = 1'b0, Reset = 1'b1, INIT_FINISH = 1'b1, data_over = 1'b0, music_en = 1'b1;
    logic [1:0]  sfx_req = 2'b00;
    logic [15:0] rom_addr, rom_data, sample;
    logic        sample_valid, sfx_busy, overrun;
    int n_cmp = 0, n_bad = 0;
    bit fixed = 0;
    int m_addr, m_div, m_off;
    bit m_act, m_id, m_pend, m_pid, m_ovr;
    logic [15:0] last_maddr, last_saddr, last_sample;

    audio_sched #(.MUSIC_END(ME), .SFX0_BASE(B0), .SFX1_BASE(B1), .SFX_LEN(LEN), .RATE_DIV(RD)) dut (
        .Clk(Clk), .Reset(Reset), .INIT_FINISH(INIT_FINISH), .data_over(data_over),
        .music_en(music_en), .sfx_req(sfx_req), .rom_addr(rom_addr), .rom_data(rom_data),
        .sample(sample), .sample_valid(sample_valid), .sfx_busy(sfx_busy), .overrun(overrun)
    );

    always #5 Clk = ~Clk;

    function automatic logic [15:0] rom_f(input logic [15:0] a);
        if (fixed) return (a < 16'(B0)) ? 16'h7000 : 16'h2000;
        return 16'(a * 16'd40503) ^ 16'h0123;
    endfunction

    always @(posedge Clk) rom_data <= rom_f(rom_addr);

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic model_reset();
        m_addr = 0; m_div = 0; m_off = 0;
        m_act = 0; m_id = 0; m_pend = 0; m_pid = 0; m_ovr = 0;
    endtask

    // Request arbitration: line clear beats drop; while busy only a strictly higher request wins.
    task automatic model_req(input logic [1:0] r);
        bit rid, cur;
        if (r == 2'b00) return;
        rid = !r[0];
        cur = m_pend ? m_pid : m_id;
        if (!(m_act || m_pend) || (!rid && cur)) begin
            m_pend = 1; m_pid = rid;
        end
    endtask

    task automatic model_accept();
        if (m_pend) begin
            m_act = 1; m_id = m_pid; m_off = 0; m_pend = 0;
        end
    endtask

    task automatic tick(input logic [1:0] pre, input logic [1:0] mid, input bit dup);
        logic [15:0] ea, sa, mw, ew, es;
        int s;
        if (pre != 2'b00) begin
            sfx_req = pre; model_req(pre); step(); sfx_req = 2'b00;
        end
        data_over = 1'b1;
        model_accept();
        ea = 16'(m_addr);
        sa = 16'((m_id ? B1 : B0) + m_off);
        mw = music_en ? rom_f(ea) : 16'h0000;
        ew = m_act ? rom_f(sa) : 16'h0000;
`ifdef AUDIO_SCHED_SFX_MIX_EN
        s = int'($signed(mw)) + int'($signed(ew));
        es = (s > 32767) ? 16'h7FFF : (s < -32768) ? 16'h8000 : 16'(s);
`else
        s = 0;
        es = m_act ? ew : mw;
`endif
        step();
        data_over = 1'b0;
        last_maddr = rom_addr;
        n_cmp++; if (rom_addr !== ea) begin n_bad++; $display("FAIL music_addr got=%h exp=%h", rom_addr, ea); end
        n_cmp++; if (rom_addr > 16'(ME)) begin n_bad++; $display("FAIL music_range got=%h exp<=%h", rom_addr, 16'(ME)); end
        n_cmp++; if (sample_valid !== 1'b0) begin n_bad++; $display("FAIL valid_t1 got=%b exp=0", sample_valid); end
        if (mid != 2'b00) begin sfx_req = mid; model_req(mid); end
        if (dup) begin data_over = 1'b1; m_ovr = 1; end
        step();
        sfx_req = 2'b00;
        data_over = 1'b0;
        n_cmp++; if (sample_valid !== 1'b0) begin n_bad++; $display("FAIL valid_t2 got=%b exp=0", sample_valid); end
        step();
        last_saddr = rom_addr;
        if (m_act) begin
            n_cmp++; if (rom_addr !== sa) begin n_bad++; $display("FAIL sfx_addr got=%h exp=%h", rom_addr, sa); end
        end
        n_cmp++; if (sample_valid !== 1'b0) begin n_bad++; $display("FAIL valid_t3 got=%b exp=0", sample_valid); end
        step();
        n_cmp++; if (sample_valid !== 1'b0) begin n_bad++; $display("FAIL valid_t4 got=%b exp=0", sample_valid); end
        step();
        last_sample = sample;
        n_cmp++; if (sample_valid !== 1'b1) begin n_bad++; $display("FAIL valid_t5 got=%b exp=1", sample_valid); end
        n_cmp++; if (sample !== es) begin n_bad++; $display("FAIL sample got=%h exp=%h", sample, es); end
        if (music_en) begin
            if (m_div == RD - 1) begin
                m_div = 0;
                m_addr = (m_addr == ME) ? 0 : m_addr + 1;
            end else m_div++;
        end
        if (m_act) begin
            if (m_off == LEN - 1) begin m_act = 0; m_off = 0; end
            else m_off++;
        end
        step();
        n_cmp++; if (sample_valid !== 1'b0) begin n_bad++; $display("FAIL valid_t6 got=%b exp=0", sample_valid); end
        n_cmp++; if (sfx_busy !== (m_act | m_pend)) begin n_bad++; $display("FAIL sfx_busy got=%b exp=%b", sfx_busy, m_act | m_pend); end
        n_cmp++; if (overrun !== m_ovr) begin n_bad++; $display("FAIL overrun got=%b exp=%b", overrun, m_ovr); end
    endtask

    task automatic do_reset();
        Reset = 1'b1; data_over = 1'b0; sfx_req = 2'b00;
        step(); step();
        Reset = 1'b0;
        model_reset();
        step();
    endtask

    task automatic test_reset();
        INIT_FINISH = 1'b1; music_en = 1'b1;
        step(); step(); step();
        n_cmp++; if (rom_addr !== 16'h0) begin n_bad++; $display("FAIL rst_rom_addr got=%h exp=0", rom_addr); end
        n_cmp++; if (sample !== 16'h0) begin n_bad++; $display("FAIL rst_sample got=%h exp=0", sample); end
        n_cmp++; if (sample_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid got=%b exp=0", sample_valid); end
        n_cmp++; if (sfx_busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy got=%b exp=0", sfx_busy); end
        n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL rst_overrun got=%b exp=0", overrun); end
        Reset = 1'b0;
        model_reset();
        step();
    endtask

    task automatic test_first();
        tick(2'b00, 2'b00, 0);
        n_cmp++; if (last_maddr !== 16'h0000) begin n_bad++; $display("FAIL first_addr got=%h exp=0000", last_maddr); end
        n_cmp++; if (last_sample !== 16'h0123) begin n_bad++; $display("FAIL first_sample got=%h exp=0123", last_sample); end
    endtask

    task automatic test_sfx_priority();
        tick(2'b10, 2'b00, 0);
        tick(2'b00, 2'b00, 0);
        tick(2'b10, 2'b00, 0);
        tick(2'b00, 2'b01, 0);
        tick(2'b00, 2'b00, 0);
        n_cmp++; if (last_saddr !== 16'(B0)) begin n_bad++; $display("FAIL restart_addr got=%h exp=%h", last_saddr, 16'(B0)); end
        n_cmp++; if (sfx_busy !== 1'b1) begin n_bad++; $display("FAIL restart_busy got=%b exp=1", sfx_busy); end
        tick(2'b11, 2'b10, 0);
        for (int i = 2; i < LEN; i++) tick(2'b00, 2'b00, 0);
        n_cmp++; if (sfx_busy !== 1'b0) begin n_bad++; $display("FAIL sfx_end_busy got=%b exp=0", sfx_busy); end
    endtask

    task automatic test_mix();
        logic [15:0] exp_s;
        fixed = 1;
`ifdef AUDIO_SCHED_SFX_MIX_EN
        exp_s = 16'h7FFF;
`else
        exp_s = 16'h2000;
`endif
        tick(2'b01, 2'b00, 0);
        n_cmp++; if (last_sample !== exp_s) begin n_bad++; $display("FAIL mix_sample got=%h exp=%h", last_sample, exp_s); end
        tick(2'b00, 2'b00, 0);
        fixed = 0;
        tick(2'b00, 2'b00, 0);
    endtask

    task automatic test_overrun();
        tick(2'b00, 2'b00, 1);
        tick(2'b00, 2'b00, 0);
        do_reset();
        n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL overrun_clear got=%b exp=0", overrun); end
    endtask

    task automatic test_abort();
        logic [15:0] keep;
        tick(2'b00, 2'b00, 0);
        tick(2'b00, 2'b00, 0);
        keep = 16'(m_addr);
        data_over = 1'b1;
        model_accept();
        step();
        data_over = 1'b0;
        step(); step();
        INIT_FINISH = 1'b0;
        step();
        n_cmp++; if (sample_valid !== 1'b0) begin n_bad++; $display("FAIL abort_valid got=%b exp=0", sample_valid); end
        INIT_FINISH = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            n_cmp++; if (sample_valid !== 1'b0) begin n_bad++; $display("FAIL abort_valid%0d got=%b exp=0", i, sample_valid); end
        end
        tick(2'b00, 2'b00, 0);
        n_cmp++; if (last_maddr !== keep) begin n_bad++; $display("FAIL abort_addr got=%h exp=%h", last_maddr, keep); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 4; i++) tick(2'b10, 2'b00, 0);
        data_over = 1'b1;
        step();
        data_over = 1'b0;
        step();
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        model_reset();
        for (int i = 0; i < 5; i++) begin
            n_cmp++; if (sample_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_valid%0d got=%b exp=0", i, sample_valid); end
            step();
        end
        n_cmp++; if (sfx_busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy got=%b exp=0", sfx_busy); end
        tick(2'b00, 2'b00, 0);
    endtask

    task automatic test_random();
        logic [1:0] pre, mid;
        for (int i = 0; i < 150; i++) begin
            music_en = ($urandom_range(0, 9) != 0);
            pre = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            mid = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            tick(pre, mid, 0);
        end
        music_en = 1'b1;
    endtask

    task automatic test_wrap();
        int guard = 0;
        music_en = 1'b1;
        while (!(m_addr == ME && m_div == 0) && guard < 100) begin
            tick(2'b00, 2'b00, 0);
            guard++;
        end
        n_cmp++; if (guard >= 100) begin n_bad++; $display("FAIL wrap_reach got=%0d exp=%0d", m_addr, ME); end
        for (int i = 0; i < RD; i++) begin
            tick(2'b00, 2'b00, 0);
            n_cmp++; if (last_maddr !== 16'(ME)) begin n_bad++; $display("FAIL wrap_top got=%h exp=%h", last_maddr, 16'(ME)); end
        end
        tick(2'b00, 2'b00, 0);
        n_cmp++; if (last_maddr !== 16'h0000) begin n_bad++; $display("FAIL wrap_zero got=%h exp=0000", last_maddr); end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_first();
        test_sfx_priority();
        test_mix();
        test_overrun();
        test_abort();
        test_reset_mid();
        test_random();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/audio_sched.md
AUDIO_SCHED -- requirements
Module: audio_sched

Interface
REQ-001 SHALL have parameters (name, default, meaning): MUSIC_END, 13435, last music ROM address; SFX0_BASE, 13436, line-clear effect start; SFX1_BASE, 15484, drop effect start; SFX_LEN, 2048, samples per effect; RATE_DIV, 10, sample ticks per music address step.
REQ-002 SHALL have ports (name, direction, width, meaning): Clk, in, 1, sole clock; Reset, in, 1, synchronous active-high reset.
REQ-003 INIT_FINISH, in, 1, codec initialised; data_over, in, 1, one-cycle sample-request tick.
REQ-004 music_en, in, 1, background music enable; sfx_req, in, 2, effect request pulses (bit0 line clear, bit1 drop).
REQ-005 rom_addr, out, 16, shared sample ROM address; rom_data, in, 16, signed ROM data, valid one cycle after rom_addr.
REQ-006 sample, out, 16, signed output sample; sample_valid, out, 1, one-cycle strobe.
REQ-007 sfx_busy, out, 1, effect playing; overrun, out, 1, sticky dropped-tick flag.

Function
REQ-008 SHALL implement states IDLE, WAIT, M_ADDR, M_DATA, S_ADDR, S_DATA, EMIT.
REQ-009 IDLE -> WAIT when INIT_FINISH=1; INIT_FINISH=0 in any state -> IDLE next cycle; no sample_valid; music address, divider and effect state held.
REQ-010 WAIT -> M_ADDR on data_over=1; then M_DATA, S_ADDR, S_DATA, EMIT, WAIT, one cycle each.
REQ-011 Fixed latency: data_over accepted in cycle T -> sample_valid=1 in cycle T+5 only.
REQ-012 M_ADDR: rom_addr = music address; M_DATA: music word captured (forced 0 if music_en=0).
REQ-013 S_ADDR: rom_addr = effect base + effect offset; S_DATA: effect word captured (forced 0 if no effect active).
REQ-014 rom_addr holds its last value outside M_ADDR/S_ADDR.
REQ-015 Music address advances by 1 in EMIT every RATE_DIV-th accepted tick (divider counts 0..RATE_DIV-1); MUSIC_END wraps to 0; held when music_en=0.
REQ-016 Effect offset advances by 1 in EMIT; after offset SFX_LEN-1 is emitted, effect ends, sfx_busy=0, offset=0.
REQ-017 sfx_req sampled every cycle in WAIT/IDLE-excluded states too; new effect starts at offset 0 on the next accepted tick.
REQ-018 Priority: bit0 over bit1; both set -> bit0; request of higher priority than the active effect restarts; equal or lower while busy ignored.
REQ-019 data_over=1 in any state other than WAIT (INIT_FINISH=1) SHALL be dropped and set overrun=1 until Reset.
REQ-020 sfx_busy=1 from the cycle after an accepted request until the effect ends.

Reset
REQ-021 Reset=1 at a clock edge: state IDLE; rom_addr, sample, music address, divider, effect offset = 0; sample_valid, sfx_busy, overrun = 0.
REQ-022 Reset mid-sequence SHALL abort without emitting a sample; Reset has priority over all inputs.

Configuration
REQ-023 Macro AUDIO_SCHED_SFX_MIX_EN defined: sample = saturating signed 16-bit sum of music and effect words (clamp +32767 / -32768).
REQ-024 Macro AUDIO_SCHED_SFX_MIX_EN undefined: sample = effect word while effect active, else music word; ROM sequencing identical.

Verification
REQ-025 Reset, INIT_FINISH=1, music_en=1, data_over in cycle 10, rom_data=0x0123 -> rom_addr=0 in cycle 11, sample=0x0123, sample_valid=1 in cycle 15 only.
REQ-026 20 ticks with music address at 13435 on tick 10 -> address becomes 0 after RATE_DIV ticks; no address above 13435 issued.
REQ-027 sfx_req=2'b10 then 2'b01 mid-effect -> S_ADDR issues 13436 on next tick; sfx_busy stays 1; after 2048 ticks sfx_busy=0.
REQ-028 Music word 0x7000, effect 0x2000 -> sample 0x7FFF with AUDIO_SCHED_SFX_MIX_EN, 0x2000 without.
REQ-029 data_over in cycle T and T+2 -> second dropped, overrun=1, one sample_valid; Reset clears overrun.
REQ-030 INIT_FINISH low in S_ADDR -> IDLE next cycle, no sample_valid; music address unchanged.
